// File: rtl/ping_pong_scheduler.sv
// ping_pong_scheduler
//
// Time-shares one ping-pong counter between two requesters. Requests are
// arbitrated round-robin. The winner's (max, min) bounds are latched and
// driven to the counter. The counter then runs until it has made a fixed
// number of natural direction reversals, or until the owner drops its
// request. The counter is then released to the other side.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req[1:0]            per-requester request
//   cfg_max0/cfg_min0   bounds offered by requester 0
//   cfg_max1/cfg_min1   bounds offered by requester 1
//   flip_req[1:0]       per-requester flip request (only the owner's bit acts)
//   cnt_dir             counter direction feedback, 1 = counting up
//   enable, flip        counter enable and one-cycle flip pulse
//   max, min            bounds driven to the counter
//   grant[1:0]          one-hot current owner, 00 = none
//   busy                high while a slice is in progress (LOAD/RUN/RELEASE)
//   cfg_err[1:0]        requester is asking with an invalid bound pair
module ping_pong_scheduler #(
  parameter int WIDTH   = 4,
  parameter int BOUNCES = 2   // natural reversals per slice, 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] cfg_max0,
  input  logic [WIDTH-1:0] cfg_min0,
  input  logic [WIDTH-1:0] cfg_max1,
  input  logic [WIDTH-1:0] cfg_min1,
  input  logic [1:0]       flip_req,
  input  logic             cnt_dir,
  output logic             enable,
  output logic             flip,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE} state_t;

  localparam logic [3:0] BOUNCE_LIMIT = 4'(BOUNCES);

  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic             flip_q, flip_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [1:0]       cfg_err_q, cfg_err_d;
  logic             owner_q, owner_d;     // index of the requester holding the slice
  logic             last_q, last_d;       // most recently released owner
  logic [3:0]       bounce_q, bounce_d;   // saturating natural-reversal count
  logic             dir_q, dir_d;         // cnt_dir as seen on the previous cycle
  logic             flip_dly_q;           // flip output delayed by one cycle
  logic [1:0]       flip_req_prev_q;      // flip_req delayed, for edge detection

  // Per-requester bounds gathered into arrays so they can be indexed by owner.
  logic [WIDTH-1:0] cfg_max_arr [2];
  logic [WIDTH-1:0] cfg_min_arr [2];
  logic [1:0]       cfg_ok;
  logic [1:0]       valid_req;

  assign cfg_max_arr[0] = cfg_max0;
  assign cfg_max_arr[1] = cfg_max1;
  assign cfg_min_arr[0] = cfg_min0;
  assign cfg_min_arr[1] = cfg_min1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      // Strictly greater: equal bounds would leave the counter nowhere to go.
      assign cfg_ok[gi]    = cfg_max_arr[gi] > cfg_min_arr[gi];
      assign valid_req[gi] = req[gi] & cfg_ok[gi];
    end
  endgenerate

  // Arbitration: a lone valid request wins; on contention the side that was
  // not released most recently wins.
  logic grant_any;
  logic grant_idx;

  always_comb begin
    grant_any = |valid_req;
    if (valid_req == 2'b11) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = valid_req[1];
    end
  end

  // RUN-state helpers.
  logic       owner_req;
  logic       flip_rise;
  logic       bounce_now;
  logic [3:0] bounce_inc;
  logic       limit_hit;

  always_comb begin
    owner_req  = req[owner_q];
    flip_rise  = flip_req[owner_q] & ~flip_req_prev_q[owner_q];
    // A direction change is natural only if no flip was issued the cycle
    // before; the counter reacts to flip one edge after the pulse.
    bounce_now = (cnt_dir != dir_q) & ~flip_dly_q;
    bounce_inc = (bounce_q == 4'hF) ? 4'hF : bounce_q + 4'd1;
    limit_hit  = bounce_now & (bounce_inc >= BOUNCE_LIMIT);
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      enable_q        <= 1'b0;
      flip_q          <= 1'b0;
      max_q           <= '1;
      min_q           <= '0;
      grant_q         <= 2'b00;
      busy_q          <= 1'b0;
      cfg_err_q       <= 2'b00;
      owner_q         <= 1'b0;
      last_q          <= 1'b1;   // so requester 0 wins the first contention
      bounce_q        <= 4'd0;
      dir_q           <= 1'b0;
      flip_dly_q      <= 1'b0;
      flip_req_prev_q <= 2'b00;
    end else begin
      state_q         <= state_d;
      enable_q        <= enable_d;
      flip_q          <= flip_d;
      max_q           <= max_d;
      min_q           <= min_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      cfg_err_q       <= cfg_err_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      bounce_q        <= bounce_d;
      dir_q           <= dir_d;
      flip_dly_q      <= flip_q;
      flip_req_prev_q <= flip_req;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_any) state_d = S_LOAD;
      S_LOAD:    state_d = S_RUN;
      S_RUN:     if (limit_hit || !owner_req) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Outputs are registered, so they are
  // derived from the state being entered.
  always_comb begin
    enable_d  = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    flip_d    = 1'b0;
    max_d     = max_q;
    min_d     = min_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    bounce_d  = bounce_q;
    dir_d     = dir_q;
    cfg_err_d = req & ~cfg_ok;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          max_d   = cfg_max_arr[grant_idx];
          min_d   = cfg_min_arr[grant_idx];
          grant_d = grant_idx ? 2'b10 : 2'b01;
        end
      end
      S_LOAD: begin
        bounce_d = 4'd0;
        dir_d    = cnt_dir;
      end
      S_RUN: begin
        dir_d = cnt_dir;
        if (bounce_now) bounce_d = bounce_inc;
        if (state_d == S_RELEASE) begin
          grant_d = 2'b00;
        end else begin
          flip_d = flip_rise;
        end
      end
      S_RELEASE: begin
        last_d = owner_q;
      end
      default: ;
    endcase

    // The owner's own flag stays quiet while it holds the counter.
    if (state_q != S_IDLE) cfg_err_d[owner_q] = 1'b0;
  end

  assign enable  = enable_q;
  assign flip    = flip_q;
  assign max     = max_q;
  assign min     = min_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ping_pong_scheduler.sv
// Bench for ping_pong_scheduler. A small ping-pong counter model is attached
// to the scheduler outputs. Each slice the stimulus expects is queued; a
// negedge monitor pops one entry per new grant and compares the grant, the
// bounds, the grant-to-enable latency, the number of enabled cycles and the
// number of flip pulses of that slice.
module tb_ping_pong_scheduler;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] cfg_max0 = 4'd9, cfg_min0 = 4'd3;
  logic [WIDTH-1:0] cfg_max1 = 4'd7, cfg_min1 = 4'd1;
  logic [1:0]       flip_req = 2'b00;
  logic             cnt_dir;
  logic             enable, flip, busy;
  logic [WIDTH-1:0] max, min;
  logic [1:0]       grant, cfg_err;

  ping_pong_scheduler #(.WIDTH(WIDTH), .BOUNCES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cfg_max0 (cfg_max0),
    .cfg_min0 (cfg_min0),
    .cfg_max1 (cfg_max1),
    .cfg_min1 (cfg_min1),
    .flip_req (flip_req),
    .cnt_dir  (cnt_dir),
    .enable   (enable),
    .flip     (flip),
    .max      (max),
    .min      (min),
    .grant    (grant),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Counter model: reloads to min counting up while disabled; when enabled,
  // flip only reverses direction, otherwise it steps and turns at the bounds.
  logic [WIDTH-1:0] cv = '0;
  logic             cd = 1'b1;
  always @(posedge clk) begin
    if (enable !== 1'b1) begin
      cv <= min;
      cd <= 1'b1;
    end else if (flip) begin
      cd <= ~cd;
    end else if (cd) begin
      if (cv >= max) begin cd <= 1'b0; cv <= cv - 1'b1; end
      else cv <= cv + 1'b1;
    end else begin
      if (cv <= min) begin cd <= 1'b1; cv <= cv + 1'b1; end
      else cv <= cv - 1'b1;
    end
  end
  assign cnt_dir = cd;

  int tests_run  = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  typedef struct {
    logic [1:0]       grant;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    int               en;
    int               fl;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [1:0] g, input logic [WIDTH-1:0] mx,
                              input logic [WIDTH-1:0] mn, input int en, input int fl);
    exp_t e;
    e.grant = g; e.max = mx; e.min = mn; e.en = en; e.fl = fl;
    return e;
  endfunction

  // Monitor / scoreboard.
  exp_t       cur;
  logic [1:0] prev_grant = 2'b00;
  bit         in_slice = 1'b0;
  bit         seen_en, hold_bad;
  int         en_cnt, fl_cnt, lat;

  always @(negedge clk) begin
    if ((grant === 2'b01 || grant === 2'b10) && prev_grant === 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("slice_grant", 32'(grant), 32'(cur.grant));
        check("slice_max", 32'(max), 32'(cur.max));
        check("slice_min", 32'(min), 32'(cur.min));
        in_slice = 1'b1;
        en_cnt = 0; fl_cnt = 0; lat = 0;
        seen_en = 1'b0; hold_bad = 1'b0;
      end
    end else if (in_slice) begin
      if (grant === 2'b00) begin
        check("slice_enable_cycles", 32'(en_cnt), 32'(cur.en));
        check("slice_flip_pulses", 32'(fl_cnt), 32'(cur.fl));
        check("slice_bounds_held", 32'(hold_bad), 32'd0);
        in_slice = 1'b0;
      end else begin
        lat++;
        if (enable === 1'b1 && !seen_en) begin
          seen_en = 1'b1;
          check("grant_to_enable", 32'(lat), 32'd1);
        end
        if (enable === 1'b1) en_cnt++;
        if (flip === 1'b1) fl_cnt++;
        if (max !== cur.max || min !== cur.min || grant !== cur.grant) hold_bad = 1'b1;
      end
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until enable reaches the given level.
  task automatic wait_enable(input logic level, input string name);
    int n = 0;
    while (enable !== level && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(enable), 32'(level));
  endtask

  initial begin
    // Reset with both requesting: nothing may be granted.
    rst = 1'b1; req = 2'b11;
    tick(); tick();
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_flip", 32'(flip), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_max", 32'(max), 32'd15);
    check("rst_min", 32'(min), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    req = 2'b00; rst = 1'b0;
    tick();

    // Contention: 12/2 and 7/1 alternate, requester 0 first.
    cfg_max0 = 4'd12; cfg_min0 = 4'd2; cfg_max1 = 4'd7; cfg_min1 = 4'd1;
    exp_q.push_back(mk(2'b01, 4'd12, 4'd2, 22, 0));
    exp_q.push_back(mk(2'b10, 4'd7, 4'd1, 14, 0));
    exp_q.push_back(mk(2'b01, 4'd12, 4'd2, 22, 0));
    req = 2'b11;
    for (int s = 0; s < 3; s++) begin
      wait_enable(1'b1, "cont_enable_rise");
      wait_enable(1'b0, "cont_enable_fall");
    end
    req = 2'b00;
    tick(); tick();

    // Single slice 9/3; bound changes during RUN must be ignored.
    cfg_max0 = 4'd9; cfg_min0 = 4'd3;
    exp_q.push_back(mk(2'b01, 4'd9, 4'd3, 14, 0));
    req = 2'b01;
    wait_enable(1'b1, "single_enable_rise");
    tick(); tick();
    cfg_max0 = 4'd13; cfg_min0 = 4'd0;
    wait_enable(1'b0, "single_enable_fall");
    req = 2'b00; cfg_max0 = 4'd9; cfg_min0 = 4'd3;
    tick(); tick();

    // Invalid config on requester 1.
    cfg_max1 = 4'd5; cfg_min1 = 4'd5; req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("inv_cfg_err", 32'(cfg_err), 32'd2);
      check("inv_grant", 32'(grant), 32'd0);
    end

    // Requester 0 valid alongside; flip held 3 cycles gives one pulse and
    // the induced reversal does not count toward the limit.
    exp_q.push_back(mk(2'b01, 4'd9, 4'd3, 15, 1));
    req = 2'b11;
    tick();
    check("inv_then_grant", 32'(grant), 32'd1);
    check("inv_then_cfg_err", 32'(cfg_err), 32'd2);
    wait_enable(1'b1, "flip_enable_rise");
    tick(); tick();
    flip_req = 2'b01;
    tick(); tick(); tick();
    flip_req = 2'b00;
    wait_enable(1'b0, "flip_enable_fall");
    req = 2'b00; cfg_max1 = 4'd7; cfg_min1 = 4'd1;
    tick(); tick();

    // Abort: owner drops req in the 4th RUN cycle.
    exp_q.push_back(mk(2'b10, 4'd7, 4'd1, 4, 0));
    req = 2'b10;
    wait_enable(1'b1, "abort_enable_rise");
    tick(); tick(); tick();
    req = 2'b00;
    tick();
    check("abort_rel_enable", 32'(enable), 32'd0);
    check("abort_rel_grant", 32'(grant), 32'd0);
    check("abort_rel_busy", 32'(busy), 32'd1);
    check("abort_rel_max", 32'(max), 32'd7);
    check("abort_rel_min", 32'(min), 32'd1);
    tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    tick();

    // Reset asserted in the 3rd RUN cycle.
    exp_q.push_back(mk(2'b01, 4'd9, 4'd3, 3, 0));
    req = 2'b01;
    wait_enable(1'b1, "mrst_enable_rise");
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mrst_enable", 32'(enable), 32'd0);
    check("mrst_grant", 32'(grant), 32'd0);
    check("mrst_max", 32'(max), 32'd15);
    check("mrst_min", 32'(min), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_flip", 32'(flip), 32'd0);
    rst = 1'b0; req = 2'b00;
    tick(); tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("no_open_slice", 32'(in_slice), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ping_pong_scheduler.md
# ping_pong_scheduler

Time-shares one parameterized ping-pong counter between two requesters. Each requester presents a (max, min) bound pair. The scheduler arbitrates round-robin, loads the winner's bounds into the counter, and runs the counter for a fixed number of natural direction reversals (bounces). It then releases the counter to the other side. It sits directly in front of the counter and drives the counter's enable, flip, max and min inputs.

## Interface
- WIDTH, 4: bit width of bounds and counter value
- BOUNCES, 2: natural direction reversals per grant slice; legal range 1..15

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  request per requester; bit i = requester i
- cfg_max0, cfg_min0  in  WIDTH each  bounds for requester 0
- cfg_max1, cfg_min1  in  WIDTH each  bounds for requester 1
- flip_req  in  2  flip request per requester; only the owner's bit is used
- cnt_dir  in  1  counter direction output, 1 = counting up
- enable  out  1  counter enable
- flip  out  1  counter flip, one-cycle pulse
- max, min  out  WIDTH each  bounds driven to the counter
- grant  out  2  one-hot current owner, 00 = none
- busy  out  1  high in LOAD, RUN and RELEASE
- cfg_err  out  2  per-requester invalid-config flag

## Operation
- All outputs are registered.
- Reset values: state = IDLE, enable = 0, flip = 0, max = all ones, min = 0, grant = 00, busy = 0, cfg_err = 00, round-robin pointer favours requester 0, bounce count = 0.
- Valid config: cfg_max > cfg_min, unsigned compare. Equal or inverted bounds are invalid.
- **IDLE**
  - enable = 0.
  - cfg_err[i] = req[i] & invalid_i, evaluated every IDLE cycle. An invalid request is never granted.
  - If exactly one valid request is present, grant it.
  - If both are valid, grant the requester not granted most recently.
  - On a grant: latch that requester's bounds into max/min, set grant one-hot, go to LOAD.
- **LOAD** (1 cycle)
  - enable = 0; max/min stable.
  - Clear bounce count. Sample dir_q <= cnt_dir.
  - Go to RUN.
- **RUN**
  - enable = 1.
  - flip pulses for 1 cycle on each rising edge of flip_req[owner]. A held flip_req gives a single pulse.
  - A bounce is a cycle with cnt_dir != dir_q and flip_q == 0, where flip_q is flip delayed one cycle. Flip-induced reversals are not counted.
  - dir_q updates every RUN cycle.
  - Go to RELEASE when the bounce count reaches BOUNCES, or when req[owner] is 0.
  - Bound or config changes from the owner during RUN are ignored; the latched values hold.
- **RELEASE** (1 cycle)
  - enable = 0, grant = 00, flip = 0.
  - Pointer records the released owner as most recent. max/min hold their last values.
  - Go to IDLE.
- Bounce counter: 4 bits, saturating. cfg_err is not raised for the owner while busy.

## Timing
- req valid and sampled in IDLE at edge t: grant and max/min are valid after t+1 (LOAD); enable rises after t+2 (RUN).
- Bounce limit reached or req dropped, detected at edge k: state is RELEASE after k (enable = 0). IDLE after k+1. Earliest new grant after k+2.
- Back-to-back contention: one IDLE cycle minimum between slices.
- flip pulse appears the cycle after flip_req rises in RUN. A flip_req rise in LOAD or IDLE is ignored.
- A rising edge with rst = 1 in any state forces all reset values at that edge, including mid-RUN. The counter stops because enable = 0.
- Simultaneous bounce-limit and req drop: single RELEASE, no difference.

## Test plan
- **Reset:** rst = 1 for 2 cycles with req = 11 -> enable = 0, grant = 00, max = 15, min = 0, cfg_err = 00, busy = 0.
- **Single slice:** req = 01, cfg_max0 = 9, cfg_min0 = 3, BOUNCES = 2, counter model attached -> grant = 01 one cycle after sample, enable one cycle later; counter reverses at 9 then at 3; RELEASE follows, then grant = 00, enable = 0.
- **Contention:** req = 11 held, both configs valid (12/2, 7/1) -> grant sequence 01, 00, 10, 00, 01; max/min alternate between 12/2 and 7/1.
- **Invalid config:** cfg_max1 = 5, cfg_min1 = 5, req = 10 -> cfg_err = 10 every cycle, grant = 00; then req = 11 with requester 0 valid -> grant = 01, with cfg_err = 10 in that IDLE cycle.
- **Flip:** in RUN, owner holds flip_req high for 3 cycles -> exactly one flip pulse; the induced reversal is not counted, so release occurs only after 2 natural bounces.
- **Abort:** owner drops req mid-RUN -> RELEASE next cycle, then IDLE. rst = 1 asserted mid-RUN -> reset values at that edge.
